// File: rtl/shot_timer_ctrl_if.sv
// Trigger/game inputs and cooldown/LED outputs of the shot timer.
// master drives the game-side inputs, slave is the controller.
interface shot_timer_ctrl_if;
    logic       game_active;
    logic       trigger_in;
    logic [1:0] shot_timer;
    logic       ready;
    logic       shot_fire;
    logic       dry_fire;
    logic [7:0] shot_count;

    modport master (
        output game_active, trigger_in,
        input  shot_timer, ready, shot_fire, dry_fire, shot_count
    );

    modport slave (
        input  game_active, trigger_in,
        output shot_timer, ready, shot_fire, dry_fire, shot_count
    );
endinterface

// File: rtl/shot_timer_ctrl.sv
// Shot cooldown controller: conditions the trigger button and
// steps the fire-ready LED value 3->0 after each accepted shot.
module shot_timer_ctrl #(
    parameter int TICK_CYCLES     = 16_666_666,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input logic              clk,
    input logic              rst_n,
    shot_timer_ctrl_if.slave bus
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t        state;
    logic          ts1, ts2;
    logic          deb, deb_q;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    timer_q;
    logic          ready_q;
    logic          fire_q;
    logic          dry_q;
    logic [7:0]    count_q;
    logic          press;

    assign press = deb & ~deb_q;

    // Debounced level only follows ts after a full run of stable samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts1     <= 1'b0;
            ts2     <= 1'b0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            ts1   <= bus.trigger_in;
            ts2   <= ts1;
            deb_q <= deb;
            if (ts2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb     <= ts2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer_q  <= 2'd3;
            ready_q  <= 1'b0;
            fire_q   <= 1'b0;
            dry_q    <= 1'b0;
            count_q  <= 8'd0;
            tick_cnt <= '0;
        end else begin
            fire_q <= 1'b0;
            dry_q  <= 1'b0;
            if (!bus.game_active) begin
                state    <= IDLE;
                timer_q  <= 2'd3;
                ready_q  <= 1'b0;
                count_q  <= 8'd0;
                tick_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state   <= READY;
                        timer_q <= 2'd0;
                        ready_q <= 1'b1;
                    end
                    READY: begin
                        if (press) begin
                            state    <= COOLDOWN;
                            fire_q   <= 1'b1;
                            timer_q  <= 2'd3;
                            ready_q  <= 1'b0;
                            tick_cnt <= '0;
                            if (count_q != 8'hFF) begin
                                count_q <= count_q + 8'd1;
                            end
                        end
                    end
                    COOLDOWN: begin
                        // A press here never disturbs the cooldown count.
                        if (press) begin
                            dry_q <= 1'b1;
                        end
                        if (tick_cnt == TW'(TICK_CYCLES - 1)) begin
                            tick_cnt <= '0;
                            timer_q  <= timer_q - 2'd1;
                            if (timer_q == 2'd1) begin
                                state   <= READY;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        timer_q <= 2'd3;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.shot_timer = timer_q;
    assign bus.ready      = ready_q;
    assign bus.shot_fire  = fire_q;
    assign bus.dry_fire   = dry_q;
    assign bus.shot_count = count_q;

endmodule

// File: tb/tb_shot_timer_ctrl.sv
// Bench for shot_timer_ctrl: directed scenarios plus random trigger
// traffic, checked cycle by cycle against a timing reference model.
module tb_shot_timer_ctrl;

    localparam int TICK = 4;
    localparam int DEB  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shot_timer_ctrl_if bus ();

    shot_timer_ctrl #(
        .TICK_CYCLES    (TICK),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: time-since-fire arithmetic, not a state machine copy.
    logic [1:0] m_pipe;
    logic       m_deb, m_debq;
    int         m_run;
    bit         m_ingame, m_cool;
    int         m_cyc, m_fire_t;
    int         m_timer, m_count;
    bit         m_ready, m_fire, m_dry;

    int obs_fire, obs_dry, win_idx, fire_at;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_edge(input bit ga, input bit trg, input bit rn);
        logic ts;
        bit   press;
        int   el;
        m_cyc++;
        if (!rn) begin
            m_pipe = 2'b00; m_deb = 1'b0; m_debq = 1'b0; m_run = 0;
            m_ingame = 0; m_cool = 0; m_timer = 3; m_count = 0;
            m_ready = 0; m_fire = 0; m_dry = 0;
            return;
        end
        ts     = m_pipe[1];
        press  = m_deb & ~m_debq;
        m_pipe = {m_pipe[0], trg};
        m_debq = m_deb;
        if (ts != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = ts;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_fire = 0;
        m_dry  = 0;
        if (!ga) begin
            m_ingame = 0; m_cool = 0; m_timer = 3;
            m_ready = 0; m_count = 0;
        end else if (!m_ingame) begin
            m_ingame = 1; m_timer = 0; m_ready = 1;
        end else if (m_cool) begin
            el    = m_cyc - m_fire_t;
            m_dry = press;
            if (el >= 3 * TICK) begin
                m_cool = 0; m_timer = 0; m_ready = 1;
            end else begin
                m_timer = 3 - el / TICK;
            end
        end else if (press) begin
            m_fire = 1; m_cool = 1; m_fire_t = m_cyc;
            m_timer = 3; m_ready = 0;
            if (m_count < 255) m_count++;
        end
    endtask

    task automatic step(input bit ga, input bit trg, input bit rn);
        bus.game_active = ga;
        bus.trigger_in  = trg;
        rst_n           = rn;
        @(posedge clk);
        model_edge(ga, trg, rn);
        #1;
        win_idx++;
        if (bus.shot_fire === 1'b1) begin
            obs_fire++;
            if (fire_at < 0) fire_at = win_idx;
        end
        if (bus.dry_fire === 1'b1) obs_dry++;
        chk("shot_timer", 32'(bus.shot_timer), 32'(m_timer));
        chk("ready", 32'(bus.ready), 32'(m_ready));
        chk("shot_fire", 32'(bus.shot_fire), 32'(m_fire));
        chk("dry_fire", 32'(bus.dry_fire), 32'(m_dry));
        chk("shot_count", 32'(bus.shot_count), 32'(m_count));
        chk("pulse_excl", 32'(bus.shot_fire & bus.dry_fire), 32'd0);
    endtask

    task automatic open_win();
        obs_fire = 0; obs_dry = 0; win_idx = 0; fire_at = -1;
    endtask

    initial begin
        int  guard;
        int  hold;
        bit  lvl, ga;
        m_cyc = 0;
        open_win();

        // 1: reset with game active and trigger held
        step(1, 1, 0);
        step(1, 1, 0);
        chk("rst_timer", 32'(bus.shot_timer), 32'd3);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_count", 32'(bus.shot_count), 32'd0);

        // 2: start a game
        step(0, 0, 1);
        step(1, 0, 1);
        chk("start_timer", 32'(bus.shot_timer), 32'd0);
        chk("start_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 1);

        // 3: held trigger fires once, cooldown 3,2,1,0
        open_win();
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, 1);
            if (i == 10) chk("cd_t2", 32'(bus.shot_timer), 32'd2);
            if (i == 14) chk("cd_t1", 32'(bus.shot_timer), 32'd1);
            if (i == 18) chk("cd_t0", 32'(bus.shot_timer), 32'd0);
        end
        chk("fire_edge", 32'(fire_at), 32'd6);
        chk("fire_once", 32'(obs_fire), 32'd1);
        chk("count_1", 32'(bus.shot_count), 32'd1);
        for (int i = 0; i < 8; i++) step(1, 0, 1);

        // 4: bouncy trigger never fires
        open_win();
        for (int r = 0; r < 5; r++) begin
            step(1, 1, 1); step(1, 1, 1);
            step(1, 0, 1); step(1, 0, 1);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 1);
        chk("bounce_fire", 32'(obs_fire), 32'd0);
        chk("bounce_cnt", 32'(bus.shot_count), 32'd1);

        // 5: fire, release, re-press while timer is 2
        open_win();
        for (int i = 1; i <= 30; i++) begin
            step(1, (i <= 3) || (i >= 8 && i <= 15), 1);
        end
        chk("dry_fire_one", 32'(obs_dry), 32'd1);
        chk("dry_shot_one", 32'(obs_fire), 32'd1);
        chk("dry_count", 32'(bus.shot_count), 32'd2);
        for (int i = 0; i < 6; i++) step(1, 0, 1);

        // 6a: abort by game_active at timer 1
        for (int i = 0; i < 6; i++) step(1, 1, 1);
        guard = 0;
        while (bus.shot_timer !== 2'd1 && guard < 40) begin
            step(1, 0, 1);
            guard++;
        end
        chk("wait_t1_a", 32'(bus.shot_timer), 32'd1);
        step(0, 0, 1);
        chk("abort_timer", 32'(bus.shot_timer), 32'd3);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_count", 32'(bus.shot_count), 32'd0);

        // 6b: abort by reset at timer 1
        step(1, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 1, 1);
        guard = 0;
        while (bus.shot_timer !== 2'd1 && guard < 40) begin
            step(1, 0, 1);
            guard++;
        end
        chk("wait_t1_b", 32'(bus.shot_timer), 32'd1);
        step(1, 0, 0);
        chk("rabort_timer", 32'(bus.shot_timer), 32'd3);
        chk("rabort_ready", 32'(bus.ready), 32'd0);
        chk("rabort_count", 32'(bus.shot_count), 32'd0);

        // held trigger across game start must not fire
        step(0, 1, 1);
        open_win();
        for (int i = 0; i < 8; i++) step(0, 1, 1);
        for (int i = 0; i < 10; i++) step(1, 1, 1);
        chk("held_start", 32'(obs_fire), 32'd0);

        // random traffic against the model
        hold = 0; lvl = 0; ga = 1;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                lvl  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 199) == 0) ga = ~ga;
            step(ga, lvl, $urandom_range(0, 599) != 0);
        end

        // saturate the shot counter
        step(0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 1);
        for (int s = 0; s < 265; s++) begin
            for (int i = 0; i < 8; i++) step(1, 1, 1);
            for (int i = 0; i < 12; i++) step(1, 0, 1);
        end
        chk("count_sat", 32'(bus.shot_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
